servo_tracker: RTL and testbench

Closed-loop pan/tilt servo driver downstream of the red-object detector. Once per video frame it captures the detector's `horz_line` (object row) and `vert_line` (object column). It computes the offset from screen centre (320, 240) and applies a proportional, dead-banded, clamped correction to two servo positions. It generates two standard 50 Hz hobby-servo PWM outputs from `VGA_clock` (25 MHz).

---
 rtl/servo_tracker_if.sv | 23 ++
 rtl/servo_tracker.sv | 205 ++++++++++++++++++++
 tb/tb_servo_tracker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/servo_tracker_if.sv
// Detector-side bus of the pan/tilt servo tracker: object position in,
// servo pulse widths and PWM out.
interface servo_tracker_if;
  logic        v_sync;
  logic [8:0]  horz_line;
  logic [9:0]  vert_line;
  logic        track_en;
  logic        pan_pwm;
  logic        tilt_pwm;
  logic [15:0] pan_pos;
  logic [15:0] tilt_pos;
  logic        target_lost;

  modport master (
    output v_sync, horz_line, vert_line, track_en,
    input  pan_pwm, tilt_pwm, pan_pos, tilt_pos, target_lost
  );

  modport slave (
    input  v_sync, horz_line, vert_line, track_en,
    output pan_pwm, tilt_pwm, pan_pos, tilt_pos, target_lost
  );
endinterface

// File: rtl/servo_tracker.sv
// Per-frame proportional pan/tilt tracker with dead-band, clamp and homing,
// driving two 50 Hz hobby-servo PWM outputs.
module servo_axis #(
    parameter int MIN_PULSE  = 25000,
    parameter int MAX_PULSE  = 50000,
    parameter int CENTER     = 37500,
    parameter int GAIN_SHIFT = 4,
    parameter int DEADBAND   = 8,
    parameter int HOME_STEP  = 250,
    parameter bit DIR        = 1'b0
) (
    input  logic               VGA_clock,
    input  logic               reset,
    input  logic               adj_en,
    input  logic               clamp_en,
    input  logic               track_en,
    input  logic               homing,
    input  logic signed [10:0] err,
    input  logic [18:0]        pcnt,
    input  logic               pcnt_wrap,
    output logic [15:0]        pos,
    output logic               pwm
);
    localparam logic signed [17:0] MIN_S   = 18'(MIN_PULSE);
    localparam logic signed [17:0] MAX_S   = 18'(MAX_PULSE);
    localparam logic signed [17:0] CEN_S   = 18'(CENTER);
    localparam logic signed [17:0] HSTEP_S = 18'(HOME_STEP);
    localparam logic signed [10:0] DB      = 11'(DEADBAND);
    localparam logic [15:0]        MIN_U   = 16'(MIN_PULSE);
    localparam logic [15:0]        MAX_U   = 16'(MAX_PULSE);
    localparam logic [15:0]        CEN_U   = 16'(CENTER);

    logic signed [10:0] err_sh;
    logic signed [17:0] corr, pos_s, diff, mag, step, cand, cand_nxt;
    logic [15:0]        sat, w;
    logic               in_band;

    assign err_sh  = err >>> GAIN_SHIFT;
    assign corr    = {{7{err_sh[10]}}, err_sh};
    assign in_band = (err <= DB) && (err >= -DB);
    assign pos_s   = $signed({2'b00, pos});
    assign diff    = pos_s - CEN_S;
    assign mag     = diff[17] ? -diff : diff;
    assign step    = (mag > HSTEP_S) ? HSTEP_S : mag;

    always_comb begin
        cand_nxt = pos_s;
        if (track_en) begin
            if (homing)
                cand_nxt = diff[17] ? pos_s + step : pos_s - step;
            else if (!in_band)
                cand_nxt = DIR ? pos_s - corr : pos_s + corr;
        end
    end

    // Inclusive saturation; in-range candidates always fit in 16 bits.
    always_comb begin
        sat = cand[15:0];
        if (cand < MIN_S)      sat = MIN_U;
        else if (cand > MAX_S) sat = MAX_U;
    end

    always_ff @(posedge VGA_clock or negedge reset) begin
        if (!reset) begin
            cand <= CEN_S;
            pos  <= CEN_U;
            w    <= CEN_U;
            pwm  <= 1'b0;
        end else begin
            if (adj_en)    cand <= cand_nxt;
            if (clamp_en)  pos  <= sat;
            // Shadow width only reloads at period end so a pulse is never cut short.
            if (pcnt_wrap) w    <= pos;
            pwm <= (pcnt < {3'b000, w});
        end
    end
endmodule

module servo_tracker #(
    parameter int PERIOD_CYC  = 500000,
    parameter int MIN_PULSE   = 25000,
    parameter int MAX_PULSE   = 50000,
    parameter int CENTER      = 37500,
    parameter int GAIN_SHIFT  = 4,
    parameter int DEADBAND    = 8,
    parameter int LOST_FRAMES = 60,
    parameter int HOME_STEP   = 250,
    parameter bit PAN_DIR     = 1'b0,
    parameter bit TILT_DIR    = 1'b0
) (
    input logic             VGA_clock,
    input logic             reset,
    servo_tracker_if.slave  bus
);
    localparam int                    NUM_AXES  = 2;
    localparam int                    LW        = $clog2(LOST_FRAMES + 1);
    localparam logic [LW-1:0]         LOST_C    = LW'(LOST_FRAMES);
    localparam logic [18:0]           PCNT_LAST = 19'(PERIOD_CYC - 1);
    localparam bit [NUM_AXES-1:0]     AXIS_DIR  = {TILT_DIR, PAN_DIR};
    localparam logic [8:0]            NO_OBJ    = 9'd240;

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ERROR, S_ADJUST, S_CLAMP} state_t;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
    } sample_t;

    state_t                        state, state_nxt;
    sample_t                       smp;
    logic                          vs_d, frame_end;
    logic                          cap_en, err_en, adj_en, clamp_en;
    logic [LW-1:0]                 lost_cnt;
    logic signed [10:0]            ex;
    logic signed [9:0]             ey;
    logic [NUM_AXES-1:0][10:0]     err;
    logic [NUM_AXES-1:0][15:0]     pos;
    logic [NUM_AXES-1:0]           pwm;
    logic [18:0]                   pcnt;
    logic                          pcnt_wrap;

    // Detector outputs settle on the frame-end edge, so sample one cycle later.
    assign frame_end = vs_d & ~bus.v_sync;
    assign ex        = $signed({1'b0, smp.col}) - 11'sd320;
    assign ey        = $signed({1'b0, smp.row}) - 10'sd240;
    assign pcnt_wrap = (pcnt == PCNT_LAST);

    always_ff @(posedge VGA_clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        err_en    = 1'b0;
        adj_en    = 1'b0;
        clamp_en  = 1'b0;
        case (state)
            S_IDLE:    if (frame_end) state_nxt = S_CAPTURE;
            S_CAPTURE: begin cap_en   = 1'b1; state_nxt = S_ERROR;  end
            S_ERROR:   begin err_en   = 1'b1; state_nxt = S_ADJUST; end
            S_ADJUST:  begin adj_en   = 1'b1; state_nxt = S_CLAMP;  end
            S_CLAMP:   begin clamp_en = 1'b1; state_nxt = S_IDLE;   end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // vs_d resets high so a low v_sync at reset release is not a frame end.
    always_ff @(posedge VGA_clock or negedge reset) begin
        if (!reset) begin
            vs_d     <= 1'b1;
            smp      <= '0;
            err      <= '0;
            lost_cnt <= '0;
        end else begin
            vs_d <= bus.v_sync;
            if (cap_en) smp <= '{row: bus.horz_line, col: bus.vert_line};
            if (err_en) begin
                err[0] <= ex;
                err[1] <= {ey[9], ey};
                if (smp.row == NO_OBJ)
                    lost_cnt <= (lost_cnt == LOST_C) ? lost_cnt : lost_cnt + 1'b1;
                else
                    lost_cnt <= '0;
            end
        end
    end

    always_ff @(posedge VGA_clock or negedge reset) begin
        if (!reset)         pcnt <= '0;
        else if (pcnt_wrap) pcnt <= '0;
        else                pcnt <= pcnt + 19'd1;
    end

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        servo_axis #(
            .MIN_PULSE  (MIN_PULSE),
            .MAX_PULSE  (MAX_PULSE),
            .CENTER     (CENTER),
            .GAIN_SHIFT (GAIN_SHIFT),
            .DEADBAND   (DEADBAND),
            .HOME_STEP  (HOME_STEP),
            .DIR        (AXIS_DIR[a])
        ) u_axis (
            .VGA_clock (VGA_clock),
            .reset     (reset),
            .adj_en    (adj_en),
            .clamp_en  (clamp_en),
            .track_en  (bus.track_en),
            .homing    (lost_cnt == LOST_C),
            .err       (err[a]),
            .pcnt      (pcnt),
            .pcnt_wrap (pcnt_wrap),
            .pos       (pos[a]),
            .pwm       (pwm[a])
        );
    end

    assign bus.pan_pos     = pos[0];
    assign bus.tilt_pos    = pos[1];
    assign bus.pan_pwm     = pwm[0];
    assign bus.tilt_pwm    = pwm[1];
    assign bus.target_lost = (lost_cnt >= LOST_C);
endmodule

// File: tb/tb_servo_tracker.sv
// Frame-level scoreboard bench for servo_tracker: table vectors, clamp/homing
// sequences, PWM width/period checks and an asynchronous reset mid-update.
module tb_servo_tracker;
    localparam int P      = 38000;
    localparam int CENTER = 37500;
    localparam int MINP   = 25000;
    localparam int MAXP   = 50000;
    localparam int LOST   = 60;

    logic VGA_clock = 1'b0;
    logic reset;
    always #20 VGA_clock = ~VGA_clock;

    servo_tracker_if bus ();

    servo_tracker #(.PERIOD_CYC(P)) dut (
        .VGA_clock (VGA_clock),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct {
        logic [8:0] h;
        logic [9:0] v;
        logic       en;
        logic       glitch;
        int         pan;
        int         tilt;
        logic       lost;
    } vec_t;

    typedef struct {
        int pan;
        int tilt;
        bit lost;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   m_pan = CENTER, m_tilt = CENTER, m_lost = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampv(input int p);
        if (p < MINP) return MINP;
        if (p > MAXP) return MAXP;
        return p;
    endfunction

    function automatic int home(input int p);
        int d = (p > CENTER) ? p - CENTER : CENTER - p;
        if (d > 250) d = 250;
        return (p > CENTER) ? p - d : p + d;
    endfunction

    function automatic void model_step(input int h, input int v, input bit en);
        int ex = v - 320;
        int ey = h - 240;
        if (h == 240) m_lost = (m_lost < LOST) ? m_lost + 1 : LOST;
        else          m_lost = 0;
        if (en) begin
            if (m_lost == LOST) begin
                m_pan  = home(m_pan);
                m_tilt = home(m_tilt);
            end else begin
                if (ex > 8 || ex < -8) m_pan  = clampv(m_pan + (ex >>> 4));
                if (ey > 8 || ey < -8) m_tilt = clampv(m_tilt + (ey >>> 4));
            end
        end
    endfunction

    // One frame: frame end at cycle T, checks lost at T+3, old pos at T+4, new at T+5.
    task automatic frame(input logic [8:0] h, input logic [9:0] v, input logic en,
                         input logic glitch);
        int   old_pan;
        exp_t e;
        @(posedge VGA_clock); #1;
        bus.horz_line = h;
        bus.vert_line = v;
        bus.track_en  = en;
        old_pan = m_pan;
        model_step(int'(h), int'(v), en);
        sb.push_back('{m_pan, m_tilt, (m_lost >= LOST)});
        @(posedge VGA_clock); #1; bus.v_sync = 1'b0;
        @(posedge VGA_clock); #1; bus.v_sync = 1'b1;
        @(posedge VGA_clock); #1; if (glitch) bus.v_sync = 1'b0;
        @(posedge VGA_clock); #1; bus.v_sync = 1'b1;
        chk("target_lost_t3", int'(bus.target_lost), int'(sb[0].lost));
        @(posedge VGA_clock); #1;
        chk("pan_hold_t4", int'(bus.pan_pos), old_pan);
        @(posedge VGA_clock); #1;
        e = sb.pop_front();
        chk("pan_pos_t5", int'(bus.pan_pos), e.pan);
        chk("tilt_pos_t5", int'(bus.tilt_pos), e.tilt);
    endtask

    task automatic drive_to(input int tgt);
        for (int n = 0; n < 2000 && m_pan != tgt; n++) begin
            int st = tgt - m_pan;
            if (st > 19)  st = 19;
            if (st < -20) st = -20;
            frame(9'd250, 10'(320 + st * 16), 1'b1, 1'b0);
        end
        chk("drive_to", int'(bus.pan_pos), tgt);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{9'd250, 10'd327, 1'b1, 1'b0, 37505, 37500, 1'b0};
        tbl[1] = '{9'd250, 10'd0,   1'b1, 1'b0, 37485, 37500, 1'b0};
        tbl[2] = '{9'd479, 10'd320, 1'b1, 1'b0, 37485, 37514, 1'b0};
        tbl[3] = '{9'd0,   10'd639, 1'b1, 1'b1, 37504, 37499, 1'b0};
        tbl[4] = '{9'd231, 10'd311, 1'b1, 1'b0, 37503, 37498, 1'b0};
        tbl[5] = '{9'd248, 10'd328, 1'b1, 1'b0, 37503, 37498, 1'b0};
        tbl[6] = '{9'd100, 10'd600, 1'b0, 1'b0, 37503, 37498, 1'b0};

        reset         = 1'b0;
        bus.v_sync    = 1'b1;
        bus.horz_line = 9'd100;
        bus.vert_line = 10'd320;
        bus.track_en  = 1'b1;
        repeat (3) @(negedge VGA_clock);
        chk("rst_pan_pos", int'(bus.pan_pos), CENTER);
        chk("rst_tilt_pos", int'(bus.tilt_pos), CENTER);
        chk("rst_pan_pwm", int'(bus.pan_pwm), 0);
        chk("rst_tilt_pwm", int'(bus.tilt_pwm), 0);
        chk("rst_target_lost", int'(bus.target_lost), 0);
        reset = 1'b1;

        fork
            begin : pwm_mon
                int hp1 = 0, ht1 = 0, hp2 = 0, ht2 = 0;
                for (int k = 1; k <= 2 * P; k++) begin
                    @(negedge VGA_clock);
                    if (k == 1)     chk("pan_first_rise", int'(bus.pan_pwm), 1);
                    if (k == P)     chk("pan_p1_last", int'(bus.pan_pwm), 0);
                    if (k == P + 1) chk("pan_p2_rise", int'(bus.pan_pwm), 1);
                    if (k <= P) begin
                        hp1 += int'(bus.pan_pwm);
                        ht1 += int'(bus.tilt_pwm);
                    end else begin
                        hp2 += int'(bus.pan_pwm);
                        ht2 += int'(bus.tilt_pwm);
                    end
                end
                chk("pan_width_p1", hp1, CENTER);
                chk("tilt_width_p1", ht1, CENTER);
                chk("pan_width_p2", hp2, CENTER + 5);
                chk("tilt_width_p2", ht2, CENTER);
            end
            begin : frames
                frame(9'd250, 10'd400, 1'b1, 1'b0);
                chk("single_pan", int'(bus.pan_pos), 37505);
                chk("single_tilt", int'(bus.tilt_pos), 37500);
                repeat (P) @(posedge VGA_clock);

                for (int i = 0; i < 7; i++) begin
                    frame(tbl[i].h, tbl[i].v, tbl[i].en, tbl[i].glitch);
                    chk("tbl_pan", int'(bus.pan_pos), tbl[i].pan);
                    chk("tbl_tilt", int'(bus.tilt_pos), tbl[i].tilt);
                    chk("tbl_lost", int'(bus.target_lost), int'(tbl[i].lost));
                end

                for (int i = 0; i < 700; i++) frame(9'd250, 10'd639, 1'b1, 1'b0);
                chk("clamp_max", int'(bus.pan_pos), MAXP);
                for (int i = 0; i < 1260; i++) frame(9'd250, 10'd0, 1'b1, 1'b0);
                chk("clamp_min", int'(bus.pan_pos), MINP);

                drive_to(38005);
                for (int i = 0; i < LOST; i++) frame(9'd240, 10'd320, 1'b1, 1'b0);
                chk("lost_set", int'(bus.target_lost), 1);
                chk("home_1", int'(bus.pan_pos), 37755);
                frame(9'd240, 10'd320, 1'b1, 1'b0);
                chk("home_2", int'(bus.pan_pos), 37505);
                frame(9'd240, 10'd320, 1'b1, 1'b0);
                chk("home_3", int'(bus.pan_pos), 37500);
                frame(9'd100, 10'd320, 1'b1, 1'b0);
                chk("lost_clear", int'(bus.target_lost), 0);
            end
        join

        // Now early in period 3 with both pulses high; abort a frame in ADJUST.
        frame(9'd250, 10'd639, 1'b1, 1'b0);
        bus.horz_line = 9'd250;
        bus.vert_line = 10'd639;
        @(posedge VGA_clock); #1; bus.v_sync = 1'b0;
        @(posedge VGA_clock); #1; bus.v_sync = 1'b1;
        @(posedge VGA_clock);
        @(posedge VGA_clock); #1;
        chk("pre_rst_pan_pwm", int'(bus.pan_pwm), 1);
        chk("pre_rst_tilt_pwm", int'(bus.tilt_pwm), 1);
        chk("pre_rst_pan_pos", int'(bus.pan_pos), CENTER + 19);
        #5 reset = 1'b0;
        #1;
        chk("mid_rst_pan_pos", int'(bus.pan_pos), CENTER);
        chk("mid_rst_tilt_pos", int'(bus.tilt_pos), CENTER);
        chk("mid_rst_pan_pwm", int'(bus.pan_pwm), 0);
        chk("mid_rst_tilt_pwm", int'(bus.tilt_pwm), 0);
        @(negedge VGA_clock);
        reset = 1'b1;
        repeat (8) @(negedge VGA_clock);
        chk("post_rst_pan_pos", int'(bus.pan_pos), CENTER);
        chk("post_rst_lost", int'(bus.target_lost), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
